// File: rtl/hex_display_scanner.sv
// Time-multiplexed N-digit hex 7-segment scanner with frame-synchronous load.
// Optional build macro LEADING_ZERO_BLANK_EN suppresses segments of leading-zero digits.
module hex_display_scanner #(
  parameter int unsigned DIGITS         = 4,
  parameter int unsigned PRESCALE       = 50000,
  parameter bit          SEG_ACTIVE_LOW = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  blank,
  output logic [7:0]            seg,
  output logic [DIGITS-1:0]     dig_en,
  output logic                  frame_tick
);

  localparam int unsigned       PW       = $clog2(PRESCALE + 1);
  localparam int unsigned       IW       = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [PW-1:0]     PS_LAST  = PW'(PRESCALE - 1);
  localparam logic [IW-1:0]     IDX_LAST = IW'(DIGITS - 1);
  localparam logic [7:0]        SEG_OFF  = {8{SEG_ACTIVE_LOW}};
  localparam logic [DIGITS-1:0] DIG_OFF  = {DIGITS{SEG_ACTIVE_LOW}};

  logic [PW-1:0]       presc;
  logic [IW-1:0]       idx;
  logic [4*DIGITS-1:0] shadow_val;
  logic [DIGITS-1:0]   shadow_dp;
  logic [4*DIGITS-1:0] pend_val;
  logic [DIGITS-1:0]   pend_dp;
  logic                pending;
  logic                tick;
  logic                wrap;

  logic [3:0]          cur_nib;
  logic                cur_dp;
  logic [DIGITS-1:0]   cur_onehot;
  logic [7:0]          seg_next;
  logic [DIGITS-1:0]   dig_next;
`ifdef LEADING_ZERO_BLANK_EN
  logic                any_nz;
  logic [DIGITS-1:0]   show_mask;
`endif

  assign tick = (presc == PS_LAST);
  assign wrap = tick && (idx == IDX_LAST);

  function automatic logic [6:0] decode(input logic [3:0] n);
    case (n)
      4'h0: decode = 7'h7E;
      4'h1: decode = 7'h30;
      4'h2: decode = 7'h6D;
      4'h3: decode = 7'h79;
      4'h4: decode = 7'h33;
      4'h5: decode = 7'h5B;
      4'h6: decode = 7'h5F;
      4'h7: decode = 7'h70;
      4'h8: decode = 7'h7F;
      4'h9: decode = 7'h7B;
      4'hA: decode = 7'h77;
      4'hB: decode = 7'h1F;
      4'hC: decode = 7'h4E;
      4'hD: decode = 7'h3D;
      4'hE: decode = 7'h4F;
      default: decode = 7'h47;
    endcase
  endfunction

  always_comb begin
    cur_nib    = '0;
    cur_dp     = 1'b0;
    cur_onehot = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      cur_onehot[i] = (idx == IW'(i));
      if (idx == IW'(i)) begin
        cur_nib = shadow_val[4*i +: 4];
        cur_dp  = shadow_dp[i];
      end
    end
`ifdef LEADING_ZERO_BLANK_EN
    // Scan from the most significant digit down; a digit is lit once any nibble at or above it is nonzero.
    any_nz    = 1'b0;
    show_mask = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      any_nz = any_nz | (|shadow_val[4*(DIGITS-1-i) +: 4]);
      show_mask[DIGITS-1-i] = any_nz || (i == DIGITS - 1);
    end
    seg_next = {cur_dp, (|(show_mask & cur_onehot)) ? decode(cur_nib) : 7'h00};
`else
    seg_next = {cur_dp, decode(cur_nib)};
`endif
    dig_next = cur_onehot;
    if (blank) begin
      seg_next = '0;
      dig_next = '0;
    end
    seg_next = seg_next ^ SEG_OFF;
    dig_next = dig_next ^ DIG_OFF;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc      <= '0;
      idx        <= '0;
      shadow_val <= '0;
      shadow_dp  <= '0;
      pend_val   <= '0;
      pend_dp    <= '0;
      pending    <= 1'b0;
      frame_tick <= 1'b0;
      seg        <= SEG_OFF;
      dig_en     <= DIG_OFF;
    end else begin
      presc      <= tick ? '0 : presc + 1'b1;
      if (tick) idx <= wrap ? '0 : idx + 1'b1;
      frame_tick <= wrap;
      // A load landing on the wrap edge goes straight to shadow and supersedes any pending data.
      if (wrap && load) begin
        shadow_val <= value;
        shadow_dp  <= dp_in;
        pending    <= 1'b0;
      end else if (wrap && pending) begin
        shadow_val <= pend_val;
        shadow_dp  <= pend_dp;
        pending    <= 1'b0;
      end else if (load) begin
        pend_val   <= value;
        pend_dp    <= dp_in;
        pending    <= 1'b1;
      end
      seg        <= seg_next;
      dig_en     <= dig_next;
    end
  end

endmodule

// File: tb/tb_hex_display_scanner.sv
// Directed bench for hex_display_scanner: table of load vectors plus hand-written frame/reset/blank sequences.
module tb_hex_display_scanner;

`ifdef LEADING_ZERO_BLANK_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load = 1'b0;
  logic [15:0] value = '0;
  logic [3:0]  dp_in = '0;
  logic        blank = 1'b0;
  logic [7:0]  seg;
  logic [3:0]  dig_en;
  logic        frame_tick;

  logic        load_l = 1'b0;
  logic [15:0] value_l = '0;
  logic [3:0]  dp_l = '0;
  logic        blank_l = 1'b0;
  logic [7:0]  seg_l;
  logic [3:0]  dig_l;
  logic        ft_l;

  logic        load_1 = 1'b0;
  logic [3:0]  value_1 = '0;
  logic [0:0]  dp_1 = '0;
  logic        blank_1 = 1'b0;
  logic [7:0]  seg_1;
  logic [0:0]  dig_1;
  logic        ft_1;

  always #5 clk = ~clk;

  hex_display_scanner #(.DIGITS(4), .PRESCALE(3), .SEG_ACTIVE_LOW(1'b0)) u_dut (
    .clk(clk), .rst_n(rst_n), .load(load), .value(value), .dp_in(dp_in), .blank(blank),
    .seg(seg), .dig_en(dig_en), .frame_tick(frame_tick));

  hex_display_scanner #(.DIGITS(4), .PRESCALE(3), .SEG_ACTIVE_LOW(1'b1)) u_low (
    .clk(clk), .rst_n(rst_n), .load(load_l), .value(value_l), .dp_in(dp_l), .blank(blank_l),
    .seg(seg_l), .dig_en(dig_l), .frame_tick(ft_l));

  hex_display_scanner #(.DIGITS(1), .PRESCALE(1), .SEG_ACTIVE_LOW(1'b0)) u_one (
    .clk(clk), .rst_n(rst_n), .load(load_1), .value(value_1), .dp_in(dp_1), .blank(blank_1),
    .seg(seg_1), .dig_en(dig_1), .frame_tick(ft_1));

  typedef struct packed {
    logic [15:0]     value;
    logic [3:0]      dp;
    logic [3:0][7:0] exp;
  } vec_t;

  vec_t            vecs [4];
  logic [3:0][7:0] zero_exp;
  logic [3:0][7:0] cur_exp;
  logic [3:0][7:0] all6d;
  logic [3:0][7:0] all79;
  logic [3:0][7:0] low_exp;
  int              compared = 0;
  int              mismatched = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One negedge sample at position k (1..) of a frame that began at the last observed frame_tick.
  task automatic sample(input int k, input logic [3:0][7:0] e, input bit blanked, input string tag);
    int d;
    @(negedge clk);
    d = ((k - 1) / 3) % 4;
    chk($sformatf("%s k=%0d dig_en", tag, k), {28'b0, dig_en}, blanked ? 32'h0 : (32'h1 << d));
    chk($sformatf("%s k=%0d seg", tag, k), {24'b0, seg}, blanked ? 32'h0 : {24'b0, e[d]});
    chk($sformatf("%s k=%0d frame_tick", tag, k), {31'b0, frame_tick}, {31'b0, (k % 12) == 0});
  endtask

  task automatic check_frame(input logic [3:0][7:0] e, input string tag);
    for (int k = 1; k <= 12; k++) sample(k, e, 1'b0, tag);
  endtask

  task automatic wait_frame(input string tag);
    bit got;
    got = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (frame_tick) begin
        got = 1'b1;
        break;
      end
    end
    chk($sformatf("%s frame wait", tag), {31'b0, got}, 32'h1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit         got;
    int         d;
    logic [3:0] oh;

    vecs[0] = '{16'h12AF, 4'b0100, {8'h30, 8'hED, 8'h77, 8'h47}};
    vecs[1] = '{16'hDB98, 4'b1001, {8'hBD, 8'h1F, 8'h7B, 8'hFF}};
    vecs[2] = '{16'h7654, 4'b0000, {8'h70, 8'h5F, 8'h5B, 8'h33}};
    vecs[3] = '{16'h1EC3, 4'b0010, {8'h30, 8'h4F, 8'hCE, 8'h79}};
    zero_exp = {LZB ? 8'h00 : 8'h7E, LZB ? 8'h00 : 8'h7E, LZB ? 8'h00 : 8'h7E, 8'h7E};
    all6d    = {8'h6D, 8'h6D, 8'h6D, 8'h6D};
    all79    = {8'h79, 8'h79, 8'h79, 8'h79};
    low_exp  = {LZB ? 8'hFF : 8'h81, LZB ? 8'hFF : 8'h81, 8'hA4, 8'h81};

    repeat (3) @(negedge clk);
    chk("reset seg", {24'b0, seg}, 32'h00);
    chk("reset dig_en", {28'b0, dig_en}, 32'h0);
    chk("reset low seg", {24'b0, seg_l}, 32'hFF);
    chk("reset low dig_en", {28'b0, dig_l}, 32'hF);
    rst_n = 1'b1;
    @(negedge clk);
    chk("release dig_en", {28'b0, dig_en}, 32'h1);
    chk("release seg", {24'b0, seg}, 32'h7E);
    chk("release low dig_en", {28'b0, dig_l}, 32'hE);
    chk("release low seg", {24'b0, seg_l}, 32'h81);
    value_l = 16'h0050;
    load_l  = 1'b1;

    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      load_l = 1'b0;
      chk($sformatf("one-digit %0d dig_en", i), {31'b0, dig_1}, 32'h1);
      chk($sformatf("one-digit %0d frame_tick", i), {31'b0, ft_1}, 32'h1);
      chk($sformatf("one-digit %0d seg", i), {24'b0, seg_1}, 32'h7E);
    end

    wait_frame("zero");
    check_frame(zero_exp, "zero");

    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      value = vecs[i].value;
      dp_in = vecs[i].dp;
      load  = 1'b1;
      @(negedge clk);
      load  = 1'b0;
      wait_frame($sformatf("vec%0d", i));
      check_frame(vecs[i].exp, $sformatf("vec%0d", i));
    end
    cur_exp = vecs[3].exp;

    // Two loads inside one frame: display holds, then the later one appears.
    dp_in = 4'b0000;
    value = 16'h1111;
    load  = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      sample(k, cur_exp, 1'b0, "midload hold");
      if (k == 1) value = 16'h2222;
      if (k == 2) load = 1'b0;
    end
    check_frame(all6d, "midload new");

    // Load driven into the wrap edge itself.
    for (int k = 1; k <= 12; k++) begin
      sample(k, all6d, 1'b0, "wrapload pre");
      if (k == 11) begin
        value = 16'h3333;
        load  = 1'b1;
      end
      if (k == 12) load = 1'b0;
    end
    check_frame(all79, "wrapload new");

    blank = 1'b1;
    for (int k = 1; k <= 24; k++) begin
      sample(k, all79, k <= 20, "blank");
      if (k == 20) blank = 1'b0;
    end

    got = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (ft_l) begin
        got = 1'b1;
        break;
      end
    end
    chk("low frame wait", {31'b0, got}, 32'h1);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      d  = (k - 1) / 3;
      oh = 4'b0001 << d;
      chk($sformatf("low k=%0d dig_en", k), {28'b0, dig_l}, {28'b0, ~oh});
      chk($sformatf("low k=%0d seg", k), {24'b0, seg_l}, {24'b0, low_exp[d]});
    end

    // Pending load immediately followed by an asynchronous reset between clock edges.
    @(negedge clk);
    value = 16'hABCD;
    load  = 1'b1;
    @(negedge clk);
    load  = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("async seg", {24'b0, seg}, 32'h00);
    chk("async dig_en", {28'b0, dig_en}, 32'h0);
    chk("async frame_tick", {31'b0, frame_tick}, 32'h0);
    chk("async low seg", {24'b0, seg_l}, 32'hFF);
    chk("async low dig_en", {28'b0, dig_l}, 32'hF);
    chk("async one dig_en", {31'b0, dig_1}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rerelease dig_en", {28'b0, dig_en}, 32'h1);
    chk("rerelease seg", {24'b0, seg}, 32'h7E);
    wait_frame("postreset");
    check_frame(zero_exp, "postreset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
